// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-client RAM port arbiter.
package ram_arb_pkg;

    typedef enum logic [2:0] {
        StWaitRdy,
        StIdle,
        StErr,
        StWrite,
        StRdCmd,
        StRdWait,
        StRdPop,
        StResp
    } arb_state_e;

    localparam logic Client0 = 1'b0;
    localparam logic Client1 = 1'b1;

    // Width of the read-timeout counter; never narrower than one bit.
    function automatic int unsigned tmo_cnt_width(input int unsigned timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/ram_arb_rr.sv
// Combinational two-way round-robin picker: on a tie the client that
// did not win last time is chosen.
module ram_arb_rr
    import ram_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_valid_o,
    output logic       grant_idx_o
);

    // Pick the winner from the request pair and the previous grant.
    always_comb begin
        grant_valid_o = |req_i;
        grant_idx_o   = Client0;
        unique case (req_i)
            2'b10:   grant_idx_o = Client1;
            2'b11:   grant_idx_o = ~last_grant_i;
            default: grant_idx_o = Client0;
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-client arbiter/sequencer in front of ram_interface_wrapper. Serialises
// accesses (one outstanding at a time) and holds ram_address stable through
// the read pop. Optional read timeout: define RAM_ARB_TIMEOUT_EN.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned DATA_BIT_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH     = 26,
    parameter int unsigned READ_TIMEOUT   = 1023
) (
    input  logic                      sys_clk,
    input  logic                      reset_n,
    input  logic                      c0_req,
    input  logic                      c0_we,
    input  logic [ADDR_WIDTH-1:0]     c0_addr,
    input  logic [DATA_BIT_WIDTH-1:0] c0_wdata,
    output logic                      c0_ack,
    output logic [DATA_BIT_WIDTH-1:0] c0_rdata,
    output logic                      c0_err,
    input  logic                      c1_req,
    input  logic                      c1_we,
    input  logic [ADDR_WIDTH-1:0]     c1_addr,
    input  logic [DATA_BIT_WIDTH-1:0] c1_wdata,
    output logic                      c1_ack,
    output logic [DATA_BIT_WIDTH-1:0] c1_rdata,
    output logic                      c1_err,
    output logic [ADDR_WIDTH-1:0]     ram_address,
    output logic [DATA_BIT_WIDTH-1:0] ram_data_in,
    output logic                      ram_write_enable,
    output logic                      ram_read_request,
    output logic                      ram_read_ack,
    input  logic [DATA_BIT_WIDTH-1:0] ram_data_out,
    input  logic                      ram_rdy,
    input  logic                      ram_rd_data_pres,
    input  logic [ADDR_WIDTH-1:0]     ram_max_address
);

    arb_state_e                state_q, state_d;
    logic                      last_grant_q, last_grant_d;
    logic                      gnt_idx_q, gnt_idx_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_BIT_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_BIT_WIDTH-1:0] c0_rdata_q, c1_rdata_q;
    logic                      c0_ack_q, c1_ack_q, c0_err_q, c1_err_q;
    logic                      we_q, rreq_q, rack_q;
    logic                      grant_valid, grant_idx, sel_we, timeout_hit, err_d;

    ram_arb_rr u_rr (
        .req_i         ({c1_req, c0_req}),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

`ifdef RAM_ARB_TIMEOUT_EN
    localparam int unsigned CntW = tmo_cnt_width(READ_TIMEOUT);
    logic [CntW-1:0] cnt_q;

    // Count cycles spent in RD_WAIT; cleared in every other state.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= (state_q == StRdWait) ? cnt_q + CntW'(1) : '0;
        end
    end

    assign timeout_hit = (state_q == StRdWait) && !ram_rd_data_pres &&
                         (cnt_q == CntW'(READ_TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign sel_we = grant_idx ? c1_we : c0_we;

    // Next-state logic; the request is latched in the grant cycle.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_idx_d    = gnt_idx_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        unique case (state_q)
            StWaitRdy: if (ram_rdy) state_d = StIdle;
            StIdle: begin
                if (!ram_rdy) begin
                    state_d = StWaitRdy;
                end else if (grant_valid) begin
                    gnt_idx_d    = grant_idx;
                    last_grant_d = grant_idx;
                    addr_d       = grant_idx ? c1_addr : c0_addr;
                    wdata_d      = grant_idx ? c1_wdata : c0_wdata;
                    if (addr_d > ram_max_address) state_d = StErr;
                    else if (sel_we)              state_d = StWrite;
                    else                          state_d = StRdCmd;
                end
            end
            StErr, StWrite, StResp: state_d = StIdle;
            StRdCmd:                state_d = StRdWait;
            StRdWait: begin
                if (ram_rd_data_pres) state_d = StRdPop;
                else if (timeout_hit) state_d = StResp;
            end
            StRdPop:                state_d = StResp;
            default:                state_d = StWaitRdy;
        endcase
    end

    // Errors come from an out-of-range grant or an expired read wait.
    assign err_d = (state_d == StErr) || timeout_hit;

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StWaitRdy;
            last_grant_q <= Client1;
            gnt_idx_q    <= Client0;
            addr_q       <= '0;
            wdata_q      <= '0;
            c0_rdata_q   <= '0;
            c1_rdata_q   <= '0;
            c0_ack_q     <= 1'b0;
            c1_ack_q     <= 1'b0;
            c0_err_q     <= 1'b0;
            c1_err_q     <= 1'b0;
            we_q         <= 1'b0;
            rreq_q       <= 1'b0;
            rack_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_idx_q    <= gnt_idx_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            c0_ack_q     <= (state_d inside {StErr, StWrite, StResp}) && (gnt_idx_d == Client0);
            c1_ack_q     <= (state_d inside {StErr, StWrite, StResp}) && (gnt_idx_d == Client1);
            c0_err_q     <= err_d && (gnt_idx_d == Client0);
            c1_err_q     <= err_d && (gnt_idx_d == Client1);
            we_q         <= (state_d == StWrite);
            rreq_q       <= (state_d == StRdCmd);
            rack_q       <= (state_d == StRdPop);
            if (state_q == StRdPop && gnt_idx_q == Client0) c0_rdata_q <= ram_data_out;
            if (state_q == StRdPop && gnt_idx_q == Client1) c1_rdata_q <= ram_data_out;
        end
    end

    assign c0_ack           = c0_ack_q;
    assign c1_ack           = c1_ack_q;
    assign c0_err           = c0_err_q;
    assign c1_err           = c1_err_q;
    assign c0_rdata         = c0_rdata_q;
    assign c1_rdata         = c1_rdata_q;
    assign ram_address      = addr_q;
    assign ram_data_in      = wdata_q;
    assign ram_write_enable = we_q;
    assign ram_read_request = rreq_q;
    assign ram_read_ack     = rack_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter.
module tb_ram_port_arbiter;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 26;

    logic          sys_clk;
    logic          reset_n;
    logic          c0_req, c0_we, c1_req, c1_we;
    logic [AW-1:0] c0_addr, c1_addr;
    logic [DW-1:0] c0_wdata, c1_wdata;
    logic          c0_ack, c1_ack, c0_err, c1_err;
    logic [DW-1:0] c0_rdata, c1_rdata;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic          ram_write_enable, ram_read_request, ram_read_ack;
    logic [DW-1:0] ram_data_out;
    logic          ram_rdy, ram_rd_data_pres;
    logic [AW-1:0] ram_max_address;

    int n_cmp;
    int n_bad;

    ram_port_arbiter #(
        .DATA_BIT_WIDTH (DW),
        .ADDR_WIDTH     (AW),
        .READ_TIMEOUT   (8)
    ) dut (
        .sys_clk          (sys_clk),
        .reset_n          (reset_n),
        .c0_req           (c0_req),
        .c0_we            (c0_we),
        .c0_addr          (c0_addr),
        .c0_wdata         (c0_wdata),
        .c0_ack           (c0_ack),
        .c0_rdata         (c0_rdata),
        .c0_err           (c0_err),
        .c1_req           (c1_req),
        .c1_we            (c1_we),
        .c1_addr          (c1_addr),
        .c1_wdata         (c1_wdata),
        .c1_ack           (c1_ack),
        .c1_rdata         (c1_rdata),
        .c1_err           (c1_err),
        .ram_address      (ram_address),
        .ram_data_in      (ram_data_in),
        .ram_write_enable (ram_write_enable),
        .ram_read_request (ram_read_request),
        .ram_read_ack     (ram_read_ack),
        .ram_data_out     (ram_data_out),
        .ram_rdy          (ram_rdy),
        .ram_rd_data_pres (ram_rd_data_pres),
        .ram_max_address  (ram_max_address)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return {c0_ack, c1_ack, c0_err, c1_err, c0_rdata, c1_rdata, ram_write_enable,
                ram_read_request, ram_read_ack, |ram_address, |ram_data_in};
    endfunction

    int strobes;
    int racks;
    int addr_bad;
    int acks;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset_n = 1'b1;
        {c0_req, c0_we, c1_req, c1_we} = '0;
        c0_addr = '0; c1_addr = '0; c0_wdata = '0; c1_wdata = '0;
        ram_data_out = '0; ram_rdy = 1'b0; ram_rd_data_pres = 1'b0;
        ram_max_address = 26'h3FF;
        #2 reset_n = 1'b0;
        #1 check("reset_outs", all_outs(), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;

        // Write held off while the wrapper is not ready.
        c0_req = 1'b1; c0_we = 1'b1; c0_addr = 26'd5; c0_wdata = 16'hA5A5;
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            strobes += int'(ram_write_enable) + int'(ram_read_request) + int'(c0_ack);
        end
        check("no_strobe_not_rdy", 64'(strobes), 64'd0);
        ram_rdy = 1'b1;
        tick();
        check("we_after_rdy_idle", 64'(ram_write_enable), 64'd0);
        tick();
        check("wr1_we", 64'(ram_write_enable), 64'd1);
        check("wr1_addr", 64'(ram_address), 64'd5);
        check("wr1_data", 64'(ram_data_in), 64'hA5A5);
        check("wr1_ack", 64'({c0_ack, c1_ack}), 64'b10);
        c0_req = 1'b0;
        tick();
        check("wr1_done", 64'({ram_write_enable, c0_ack}), 64'd0);

        // Both clients write continuously: grants alternate from client 0.
        reset_n = 1'b0;
        c0_req = 1'b1; c0_we = 1'b1; c0_addr = 26'd10; c0_wdata = 16'h1111;
        c1_req = 1'b1; c1_we = 1'b1; c1_addr = 26'd20; c1_wdata = 16'h2222;
        tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("alt_we", 64'(ram_write_enable), 64'd1);
            check("alt_addr", 64'(ram_address), (i % 2 == 0) ? 64'd10 : 64'd20);
            check("alt_data", 64'(ram_data_in), (i % 2 == 0) ? 64'h1111 : 64'h2222);
            check("alt_ack", 64'({c0_ack, c1_ack}), (i % 2 == 0) ? 64'b10 : 64'b01);
            if (i == 3) begin
                c0_req = 1'b0;
                c1_req = 1'b0;
            end
            tick();
            check("alt_gap", 64'({ram_write_enable, c0_ack, c1_ack}), 64'd0);
        end

        // Client 1 reads 0x123; data present 10 cycles after the request.
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = 26'h123;
        racks = 0; addr_bad = 0; acks = 0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            racks += int'(ram_read_ack);
            acks += int'(c1_ack);
            if (c <= 13 && ram_address !== 26'h123) addr_bad++;
            if (c == 1) check("rd_req", 64'({ram_read_request, ram_write_enable}), 64'b10);
            if (c == 2) check("rd_req_once", 64'(ram_read_request), 64'd0);
            if (c == 11) begin
                ram_rd_data_pres = 1'b1;
                ram_data_out = 16'hBEEF;
            end
            if (c == 12) begin
                check("rd_pop", 64'({ram_read_ack, c1_ack}), 64'b10);
                ram_rd_data_pres = 1'b0;
            end
            if (c == 13) begin
                check("rd_ack", 64'({c1_ack, c1_err, c0_ack}), 64'b100);
                check("rd_data", 64'(c1_rdata), 64'hBEEF);
                c1_req = 1'b0;
                ram_data_out = 16'h0000;
            end
            if (c == 14) check("rd_data_held", 64'(c1_rdata), 64'hBEEF);
        end
        check("rd_pop_count", 64'(racks), 64'd1);
        check("rd_ack_count", 64'(acks), 64'd1);
        check("rd_addr_stable", 64'(addr_bad), 64'd0);

        // Out-of-range access.
        c0_req = 1'b1; c0_we = 1'b1; c0_addr = 26'h400; c0_wdata = 16'h7777;
        tick();
        check("oor_ack_err", 64'({c0_ack, c0_err, c1_ack}), 64'b110);
        check("oor_no_strobe", 64'({ram_write_enable, ram_read_request}), 64'd0);
        c0_req = 1'b0;
        tick();
        check("oor_done", 64'({c0_ack, c0_err, ram_write_enable, ram_read_request}), 64'd0);

        // Async reset during RD_WAIT.
        c0_req = 1'b1; c0_we = 1'b0; c0_addr = 26'h55;
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        #1 check("rst_mid_outs", all_outs(), 64'd0);
        acks = 0;
        tick();
        acks += int'(c0_ack) + int'(c1_ack);
        tick();
        acks += int'(c0_ack) + int'(c1_ack);
        check("rst_no_ack", 64'(acks), 64'd0);
        c0_we = 1'b1; c0_addr = 26'd7; c0_wdata = 16'h0707;
        ram_rdy = 1'b0;
        reset_n = 1'b1;
        strobes = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            strobes += int'(ram_write_enable) + int'(ram_read_request) + int'(c0_ack);
        end
        check("rst_wait_rdy", 64'(strobes), 64'd0);
        ram_rdy = 1'b1;
        tick();
        check("rst_idle", 64'(ram_write_enable), 64'd0);
        tick();
        check("rst_resume_wr", 64'({ram_write_enable, c0_ack, ram_address[7:0]}), 64'h307);
        c0_req = 1'b0;
        tick();

`ifdef RAM_ARB_TIMEOUT_EN
        // Read with no data: err after 8 cycles of RD_WAIT, no pop.
        c0_req = 1'b1; c0_we = 1'b0; c0_addr = 26'h40;
        racks = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            racks += int'(ram_read_ack);
            if (c == 9) check("tmo_not_yet", 64'(c0_ack), 64'd0);
            if (c == 10) begin
                check("tmo_ack_err", 64'({c0_ack, c0_err}), 64'b11);
                check("tmo_rdata", 64'(c0_rdata), 64'd0);
                c0_req = 1'b0;
            end
        end
        check("tmo_no_pop", 64'(racks), 64'd0);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-client arbiter and sequencer in front of `ram_interface_wrapper`. It shares the wrapper's single command/data port between two requesters, for example a sample recorder and a playback engine. It serialises accesses so that only one operation is outstanding at a time, and it holds the address stable through the read pop, because the wrapper selects `data_out` from the address. Both clients see one simple req/ack handshake.

## Interface
- `DATA_BIT_WIDTH`, 16: client and wrapper data width.
- `ADDR_WIDTH`, 26: client and wrapper address width.
- `READ_TIMEOUT`, 1023: cycles to wait for read data before aborting. Used only with `RAM_ARB_TIMEOUT_EN`.
- `sys_clk` in 1: single clock. Same clock as the wrapper's `sys_clk`.
- `reset_n` in 1: asynchronous, active-low reset.
- `c0_req`, `c1_req` in 1: request, level. Held until the matching ack.
- `c0_we`, `c1_we` in 1: 1 = write, 0 = read. Valid while req is high.
- `c0_addr`, `c1_addr` in ADDR_WIDTH: word address. Valid while req is high.
- `c0_wdata`, `c1_wdata` in DATA_BIT_WIDTH: write data.
- `c0_ack`, `c1_ack` out 1: one-cycle completion pulse.
- `c0_rdata`, `c1_rdata` out DATA_BIT_WIDTH: read data. Valid in the ack cycle and held until the next read for that client.
- `c0_err`, `c1_err` out 1: coincident with ack. Signals an out-of-range address or a read timeout.
- `ram_address` out ADDR_WIDTH, `ram_data_in` out DATA_BIT_WIDTH, `ram_write_enable` out 1, `ram_read_request` out 1, `ram_read_ack` out 1: drive the wrapper.
- `ram_data_out` in DATA_BIT_WIDTH, `ram_rdy` in 1, `ram_rd_data_pres` in 1, `ram_max_address` in ADDR_WIDTH: from the wrapper.

## Operation
- Reset values: all outputs are 0, state is WAIT_RDY, and `last_grant` = 1, so client 0 wins the first tie.
- All `ram_*` and `cN_*` outputs are registered.
- WAIT_RDY: stay until `ram_rdy` = 1, then go to IDLE.
- IDLE:
  - If `ram_rdy` = 0, go to WAIT_RDY.
  - Otherwise, pick a requester:
    - If only one client requests, that client wins.
    - If both request, the client ≠ `last_grant` wins.
  - On a grant, latch the winner's index, we, addr and wdata, and update `last_grant`.
  - Next state depends on the latched request:
    - addr > `ram_max_address` → ERR.
    - we = 1 → WRITE.
    - we = 0 → RD_CMD.
- ERR: pulse ack and err for the granted client. No RAM access. Return to IDLE.
- WRITE:
  - `ram_write_enable` = 1 for exactly one cycle, with `ram_address` and `ram_data_in` valid.
  - The granted client's ack pulses in the same cycle.
  - Return to IDLE.
- RD_CMD: `ram_read_request` = 1 for exactly one cycle. Go to RD_WAIT.
- RD_WAIT: wait for `ram_rd_data_pres` = 1, then go to RD_POP.
- RD_POP:
  - `ram_read_ack` = 1 for one cycle.
  - `ram_data_out` is captured into the granted client's rdata at the end of this cycle.
  - Go to RESP.
- RESP: pulse the granted client's ack. Return to IDLE.
- `ram_address` is held from the grant until the state returns to IDLE; it never changes during RD_POP.
- `ram_write_enable` and `ram_read_request` are never high in the same cycle.
- `ram_rdy` falling mid-operation: the current operation completes normally, then IDLE goes to WAIT_RDY.
- Async reset mid-operation: everything returns immediately to reset values. No ack is issued for the aborted operation.

## Timing
- Grant cycle T is in IDLE.
- Write: `ram_write_enable` and ack in T+1; next grant possible in T+2.
- Out-of-range access: ack and err in T+1.
- Read:
  - `ram_read_request` in T+1.
  - RD_WAIT starts in T+2.
  - If `ram_rd_data_pres` is first seen high in cycle R, `ram_read_ack` is in R+1 and ack plus rdata are in R+2.
  - Minimum read latency is 4 cycles from grant to ack.
- Client rule: req may stay high after ack only to signal a new request. The cycle after ack is IDLE and samples req afresh.
- Back-to-back writes from one client sustain one write every 2 cycles.

## Configuration
- `RAM_ARB_TIMEOUT_EN` defined:
  - A counter runs in RD_WAIT.
  - After `READ_TIMEOUT` cycles without `ram_rd_data_pres`, go to RESP with err = 1 and rdata unchanged.
  - No pop is performed.
- `RAM_ARB_TIMEOUT_EN` undefined: RD_WAIT waits indefinitely. err is only ever set for an out-of-range address. No counter logic is built.

## Structure
- Package `ram_arb_pkg` holds:
  - State encodings: WAIT_RDY, IDLE, ERR, WRITE, RD_CMD, RD_WAIT, RD_POP, RESP.
  - The client-index constants.
  - The timeout counter width, computed as clog2 of `READ_TIMEOUT`+1.
- One sub-module, `ram_arb_rr`: combinational two-way round-robin picker with inputs req[1:0] and last_grant, and outputs grant_valid and grant_idx.

## Test plan
- `ram_rdy` held 0 for 20 cycles while `c0_req` (write, addr 5) is high → no RAM strobes. After `ram_rdy` rises, `ram_write_enable` fires once with addr 5, and `c0_ack` pulses in the same cycle.
- Both clients request writes continuously → grants alternate 0, 1, 0, 1, with one `ram_write_enable` every 2 cycles and never a double grant.
- c1 reads addr 0x123; the model raises `ram_rd_data_pres` 10 cycles after `ram_read_request` with `ram_data_out` = 0xBEEF → one `ram_read_ack`, `ram_address` stays 0x123 throughout, and `c1_rdata` = 0xBEEF with `c1_ack` two cycles after data is present.
- c0 accesses addr = `ram_max_address`+1 → `c0_ack` and `c0_err` in T+1, and no write or read strobe.
- With `RAM_ARB_TIMEOUT_EN` and `READ_TIMEOUT` = 8, no read data arrives → ack plus err after 8 RD_WAIT cycles, and `ram_read_ack` never asserts.
- `reset_n` is pulsed low during RD_WAIT → all outputs are 0 immediately, no ack is issued, and the block resumes from WAIT_RDY.
